multiword_add_sequencer: RTL

- Sequences wide additions and subtractions (WORDS x 16 bits) through the team's single combinational 16-bit Brent-Kung adder, one 16-bit slice per cycle, least significant slice first.
- Sits directly upstream of that adder. It drives the adder's A/B/Cin and captures its Sum/Cout, rippling the carry between slices in a register.
- Exposes valid/ready handshakes on both its operand side and its result side.

---
 rtl/multiword_add_sequencer.sv | 74 +++++++
 1 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: runs a WORDS x 16-bit add/subtract through one external 16-bit adder, LS slice first
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                op_cin,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] res_sum,
  output logic                res_cout,
  output logic                res_ovf,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_sum,
  input  logic                add_cout
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg, b_reg;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign add_a     = state == RUN ? a_reg[idx*16 +: 16] : '0;
  assign add_b     = state == RUN ? b_reg[idx*16 +: 16] : '0;
  assign add_cin   = state == RUN ? carry : 1'b0;
  // b_reg holds the already-inverted subtrahend, so overflow is judged on the effective operand
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg   <= op_a;
          b_reg   <= op_sub ? ~op_b : op_b;
          carry   <= op_sub | op_cin;
          idx     <= '0;
          res_sum <= '0;
          state   <= RUN;
        end
        RUN: begin
          res_sum[idx*16 +: 16] <= add_sum;
          carry <= add_cout;
          if (idx == IW'(WORDS - 1)) begin
            res_cout <= add_cout;
            res_ovf  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]);
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
